// File: rtl/xsleena_irq_pkg.sv
// ---------------------------------------------------------------------------
// xsleena_irq_pkg
//   Shared definitions for the 6809 interrupt request stage.
//   - N_SRC            : number of interrupt sources (NMI, FIRQ, IRQ)
//   - irq_src_e        : source index; doubles as the bit position inside the
//                        en_din / ack_we / pending / enable vectors
//   - irq_state_e      : per-source latch state (IDLE / PEND)
//   - src_vec()        : packs the three source signals in {IRQ,FIRQ,NMI} order
// ---------------------------------------------------------------------------
package xsleena_irq_pkg;

  localparam int N_SRC = 3;

  typedef enum logic [1:0] {
    SRC_NMI  = 2'd0,
    SRC_FIRQ = 2'd1,
    SRC_IRQ  = 2'd2
  } irq_src_e;

  // Integer bit positions for generate loops and vector slicing.
  localparam int BIT_NMI  = 0;
  localparam int BIT_FIRQ = 1;
  localparam int BIT_IRQ  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } irq_state_e;

  // Keeps the {IRQ,FIRQ,NMI} ordering in one place.
  function automatic logic [N_SRC-1:0] src_vec(input logic irq,
                                               input logic firq,
                                               input logic nmi);
    return {irq, firq, nmi};
  endfunction

endpackage

// File: rtl/xsleena_irq_src.sv
// ---------------------------------------------------------------------------
// xsleena_irq_src
//   One interrupt source: rising-edge detector, IDLE/PEND request latch and
//   a saturating counter of edges that arrived while already pending.
//
//   Ports
//     clk       in   1      single clock
//     RSTn      in   1      asynchronous active-low reset
//     src       in   1      raw source level; a rising edge requests
//     gate      in   1      1 = edges may be accepted this cycle
//     en        in   1      effective enable (already includes a same-cycle
//                           enable write); 0 forces the latch to IDLE
//     ack       in   1      acknowledge strobe, clears the latch
//     pending   out  1      latch state, 1 = PEND
//     miss_cnt  out  CNT_W  edges lost because the request was still pending
//
//   Next-state priority (top wins):
//     disabled -> IDLE; edge+ack -> PEND; edge while PEND -> count a miss;
//     edge -> PEND; ack -> IDLE.
// ---------------------------------------------------------------------------
module xsleena_irq_src
  import xsleena_irq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             src,
  input  logic             gate,
  input  logic             en,
  input  logic             ack,
  output logic             pending,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  irq_state_e       r_state;
  logic             r_src;
  logic [CNT_W-1:0] r_cnt;

  logic             w_edge;
  logic             w_cnt_max;

  // Gate only qualifies acceptance; the history register tracks the raw
  // level so a gated edge is consumed rather than deferred.
  assign w_edge    = src & ~r_src & gate;
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      // History starts high so a source already high at release is not an edge.
      r_src   <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_src <= src;
      if (!en) begin
        r_state <= ST_IDLE;
      end else if (w_edge && ack) begin
        // The new request wins over the acknowledge of the old one.
        r_state <= ST_PEND;
      end else if (w_edge) begin
        if (r_state == ST_PEND && !w_cnt_max) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        r_state <= ST_PEND;
      end else if (ack) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign pending  = (r_state == ST_PEND);
  assign miss_cnt = r_cnt;

endmodule

// File: rtl/xsleena_irq_ctrl.sv
// ---------------------------------------------------------------------------
// xsleena_irq_ctrl
//   CPU interrupt request stage behind the video timing generator. Turns the
//   timing outputs and an external request into latched, acknowledge-cleared,
//   active-low 6809 interrupt lines.
//     NMI  <- VBLK rising edge
//     FIRQ <- IMS rising edge (optionally suppressed during VBLK)
//     IRQ  <- irq_ext rising edge
//
//   Parameters
//     CNT_W        width of each saturating missed-interrupt counter
//     EN_RST       enable register value after reset, {IRQ,FIRQ,NMI}
//     FIRQ_IN_VBL  1: FIRQ edges accepted in VBLK; 0: ignored while VBLK=1
//
//   Ports
//     clk       in   1        master clock
//     RSTn      in   1        asynchronous active-low reset
//     VBLK      in   1        vertical blank
//     IMS       in   1        FIRQ timing source
//     irq_ext   in   1        external IRQ source
//     en_we     in   1        load en_din into the enable register
//     en_din    in   3        new enables {IRQ,FIRQ,NMI}
//     ack_we    in   3        acknowledge strobes {IRQ,FIRQ,NMI}
//     NMIn      out  1        low while NMI pending
//     FIRQn     out  1        low while FIRQ pending
//     IRQn      out  1        low while IRQ pending
//     pending   out  3        pending flags {IRQ,FIRQ,NMI}
//     enable    out  3        current enable register
//     miss_cnt  out  3*CNT_W  missed counters {IRQ,FIRQ,NMI}
//
//   Handshake: no valid/ready here. en_we and ack_we are single-cycle
//   strobes sampled on the rising clock edge; every strobe bit seen high is
//   acted on in that cycle, independently per source.
// ---------------------------------------------------------------------------
module xsleena_irq_ctrl
  import xsleena_irq_pkg::*;
#(
  parameter int         CNT_W       = 4,
  parameter logic [2:0] EN_RST      = 3'b000,
  parameter bit         FIRQ_IN_VBL = 1'b1
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic                   VBLK,
  input  logic                   IMS,
  input  logic                   irq_ext,
  input  logic                   en_we,
  input  logic [N_SRC-1:0]       en_din,
  input  logic [N_SRC-1:0]       ack_we,
  output logic                   NMIn,
  output logic                   FIRQn,
  output logic                   IRQn,
  output logic [N_SRC-1:0]       pending,
  output logic [N_SRC-1:0]       enable,
  output logic [N_SRC*CNT_W-1:0] miss_cnt
);

  logic [N_SRC-1:0]       r_en;
  logic [N_SRC-1:0]       w_en_next;
  logic [N_SRC-1:0]       w_src;
  logic [N_SRC-1:0]       w_gate;
  logic [N_SRC-1:0]       w_pend;
  logic [N_SRC*CNT_W-1:0] w_miss;

  // A same-cycle enable write already governs the edge seen in that cycle.
  assign w_en_next = en_we ? en_din : r_en;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_en <= EN_RST;
    end else begin
      r_en <= w_en_next;
    end
  end

  assign w_src = src_vec(irq_ext, IMS, VBLK);

  always_comb begin
    w_gate           = '1;
    w_gate[BIT_FIRQ] = FIRQ_IN_VBL ? 1'b1 : ~VBLK;
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    xsleena_irq_src #(
      .CNT_W (CNT_W)
    ) u_src (
      .clk      (clk),
      .RSTn     (RSTn),
      .src      (w_src[g]),
      .gate     (w_gate[g]),
      .en       (w_en_next[g]),
      .ack      (ack_we[g]),
      .pending  (w_pend[g]),
      .miss_cnt (w_miss[g*CNT_W +: CNT_W])
    );
  end

  // Lines are pure inversions of the latch flops: no input-to-output path.
  assign NMIn     = ~w_pend[BIT_NMI];
  assign FIRQn    = ~w_pend[BIT_FIRQ];
  assign IRQn     = ~w_pend[BIT_IRQ];
  assign pending  = w_pend;
  assign enable   = r_en;
  assign miss_cnt = w_miss;

endmodule

// File: tb/tb_xsleena_irq_ctrl.sv
module tb_xsleena_irq_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RSTn;
  always #5 clk = ~clk;

  logic       VBLK, IMS, irq_ext, en_we;
  logic [2:0] en_din, ack_we;

  // Instance a: defaults (EN_RST=000, FIRQ_IN_VBL=1)
  logic        a_NMIn, a_FIRQn, a_IRQn;
  logic [2:0]  a_pending, a_enable;
  logic [11:0] a_miss;
  // Instance b: EN_RST=111, FIRQ_IN_VBL=0
  logic        b_NMIn, b_FIRQn, b_IRQn;
  logic [2:0]  b_pending, b_enable;
  logic [11:0] b_miss;

  xsleena_irq_ctrl #(.CNT_W(CNT_W), .EN_RST(3'b000), .FIRQ_IN_VBL(1'b1)) dut_a (
    .clk(clk), .RSTn(RSTn), .VBLK(VBLK), .IMS(IMS), .irq_ext(irq_ext),
    .en_we(en_we), .en_din(en_din), .ack_we(ack_we),
    .NMIn(a_NMIn), .FIRQn(a_FIRQn), .IRQn(a_IRQn),
    .pending(a_pending), .enable(a_enable), .miss_cnt(a_miss)
  );

  xsleena_irq_ctrl #(.CNT_W(CNT_W), .EN_RST(3'b111), .FIRQ_IN_VBL(1'b0)) dut_b (
    .clk(clk), .RSTn(RSTn), .VBLK(VBLK), .IMS(IMS), .irq_ext(irq_ext),
    .en_we(en_we), .en_din(en_din), .ack_we(ack_we),
    .NMIn(b_NMIn), .FIRQn(b_FIRQn), .IRQn(b_IRQn),
    .pending(b_pending), .enable(b_enable), .miss_cnt(b_miss)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: enable word, pending flags, last source levels, miss counts.
  logic [2:0] p_en_rst [2];
  bit         p_fiv    [2];
  logic [2:0] m_en     [2];
  logic [2:0] m_pend   [2];
  logic [2:0] m_last   [2];
  int         m_cnt    [2][3];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_en[k]   = p_en_rst[k];
      m_pend[k] = 3'b000;
      m_last[k] = 3'b111;
      for (int s = 0; s < 3; s++) m_cnt[k][s] = 0;
    end
  endtask

  task automatic model_clock();
    logic [2:0] lvl;
    logic [2:0] en_now;
    bit         rise;
    lvl = {irq_ext, IMS, VBLK};
    for (int k = 0; k < 2; k++) begin
      en_now = en_we ? en_din : m_en[k];
      for (int s = 0; s < 3; s++) begin
        rise = lvl[s] && !m_last[k][s];
        if (s == 1 && !p_fiv[k] && VBLK) rise = 0;
        if (!en_now[s])                     m_pend[k][s] = 1'b0;
        else if (rise && ack_we[s])         m_pend[k][s] = 1'b1;
        else if (rise && m_pend[k][s]) begin
          if (m_cnt[k][s] < CNT_MAX) m_cnt[k][s]++;
        end
        else if (rise)                      m_pend[k][s] = 1'b1;
        else if (ack_we[s])                 m_pend[k][s] = 1'b0;
      end
      m_last[k] = lvl;
      m_en[k]   = en_now;
    end
  endtask

  task automatic check_all(input string ph);
    logic [2:0]  o_pend, o_en, o_lines;
    logic [11:0] o_miss, e_miss;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_pend = a_pending; o_en = a_enable; o_lines = {a_IRQn, a_FIRQn, a_NMIn}; o_miss = a_miss;
      end else begin
        o_pend = b_pending; o_en = b_enable; o_lines = {b_IRQn, b_FIRQn, b_NMIn}; o_miss = b_miss;
      end
      e_miss = {4'(m_cnt[k][2]), 4'(m_cnt[k][1]), 4'(m_cnt[k][0])};
      chk($sformatf("%s_%0d_pending", ph, k), {29'd0, o_pend}, {29'd0, m_pend[k]});
      chk($sformatf("%s_%0d_enable", ph, k), {29'd0, o_en}, {29'd0, m_en[k]});
      chk($sformatf("%s_%0d_lines", ph, k), {29'd0, o_lines}, {29'd0, ~m_pend[k]});
      chk($sformatf("%s_%0d_miss", ph, k), {20'd0, o_miss}, {20'd0, e_miss});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string ph);
    @(posedge clk);
    if (RSTn) model_clock();
    #1;
    check_all(ph);
  endtask

  task automatic cyc(input string ph, input logic v, input logic ims, input logic irq,
                     input logic we, input logic [2:0] din, input logic [2:0] ack);
    VBLK = v; IMS = ims; irq_ext = irq; en_we = we; en_din = din; ack_we = ack;
    tick(ph);
    en_we = 1'b0; ack_we = 3'b000;
  endtask

  task automatic async_reset(input string ph);
    #2 RSTn = 1'b0;
    model_reset();
    #1 check_all(ph);
    @(negedge clk);
    RSTn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    p_en_rst[0] = 3'b000; p_fiv[0] = 1'b1;
    p_en_rst[1] = 3'b111; p_fiv[1] = 1'b0;
    RSTn = 1'b0; VBLK = 1'b1; IMS = 1'b0; irq_ext = 1'b0;
    en_we = 1'b0; en_din = 3'b000; ack_we = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    RSTn = 1'b1;

    // Source already high at release must not fire (b has all enables on).
    repeat (3) cyc("rel", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("rel_b_nmin", {31'd0, b_NMIn}, 32'd1);
    chk("rel_b_pending", {29'd0, b_pending}, 32'd0);

    // NMI: enable, VBLK rise, then acknowledge.
    cyc("nmi", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("nmi", 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000);
    cyc("nmi", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("nmi_low", {31'd0, a_NMIn}, 32'd0);
    repeat (4) cyc("nmi", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("nmi_held", {31'd0, a_NMIn}, 32'd0);
    cyc("nmi", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
    chk("nmi_ack", {31'd0, a_NMIn}, 32'd1);

    // FIRQ: 20 IMS edges with no ack, counter must saturate.
    cyc("firq", 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000);
    for (int i = 0; i < 20; i++) begin
      cyc("firq", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
      chk("firq_low", {31'd0, a_FIRQn}, 32'd0);
      cyc("firq", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    end
    chk("firq_sat", {28'd0, a_miss[7:4]}, 32'd15);

    // IRQ: edge and ack in the same cycle while pending.
    cyc("irq", 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3'b000);
    cyc("irq", 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    cyc("irq", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("irq", 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100);
    chk("irq_edge_ack_pend", {31'd0, a_pending[2]}, 32'd1);
    chk("irq_edge_ack_cnt", {28'd0, a_miss[11:8]}, 32'd0);

    // FIRQ gating during VBLK (instance b only).
    cyc("gate", 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000);
    cyc("gate", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("gate_b_vbl", {31'd0, b_FIRQn}, 32'd1);
    chk("gate_a_vbl", {31'd0, a_FIRQn}, 32'd0);
    cyc("gate", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("gate", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    cyc("gate", 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    chk("gate_b_open", {31'd0, b_FIRQn}, 32'd0);

    // All pending, then disable everything at once.
    cyc("all", 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b000);
    cyc("all", 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
    chk("all_pend", {29'd0, a_pending}, 32'd7);
    cyc("all", 1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
    chk("all_off", {29'd0, a_IRQn, a_FIRQn, a_NMIn}, 32'd7);

    // Mid-frame reset.
    async_reset("midrst");
    chk("midrst_cnt", {20'd0, a_miss}, 32'd0);
    chk("midrst_en_b", {29'd0, b_enable}, 32'd7);

    // Randomized traffic against the model.
    VBLK = 1'b0; IMS = 1'b0; irq_ext = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic       v, ims, irq, we;
      logic [2:0] din, ack;
      v   = ($urandom_range(0, 7) == 0) ? ~VBLK : VBLK;
      ims = ($urandom_range(0, 2) == 0) ? ~IMS : IMS;
      irq = ($urandom_range(0, 4) == 0) ? ~irq_ext : irq_ext;
      we  = ($urandom_range(0, 11) == 0);
      din = 3'($urandom_range(0, 7));
      ack = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cyc("rand", v, ims, irq, we, din, ack);
      if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
